uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter: OSR, default 16, clock-enable ticks per serial bit time.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 baud_pulse  input  1  one-clk-wide oversample tick; all bit timing counts these.
REQ-005 fifo_dout  input  8  TX FIFO head byte, valid combinationally while fifo_empty=0.
REQ-006 fifo_empty  input  1  TX FIFO empty flag.
REQ-007 fifo_pop  output  1  one-clk pop strobe to the TX FIFO.
REQ-008 wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-009 stb  input  1  stop bits: 0=1 stop; 1=1.5 stop when wls=00, otherwise 2.
REQ-010 pen  input  1  parity enable.
REQ-011 eps  input  1  even parity select.
REQ-012 sp  input  1  stick parity.
REQ-013 set_break  input  1  force serial line low.
REQ-014 tx  output  1  serial output, idle high.
REQ-015 tx_busy  output  1  frame in progress (state != IDLE).
REQ-016 temt  output  1  transmitter empty: state IDLE and fifo_empty=1.

Function
REQ-017 States: IDLE, START, DATA, PARITY, STOP, encoded in a registered state machine.
REQ-018 IDLE with fifo_empty=0: assert fifo_pop for exactly one clk, load fifo_dout into shift register, latch wls/stb/pen/eps/sp, go to START next clk.
REQ-019 Frame-format inputs are used only as latched at load; changes mid-frame do not affect the current frame.
REQ-020 START: tx=0 for OSR baud_pulse ticks, then DATA.
REQ-021 DATA: LSB first, each bit held OSR ticks; after 5+wls bits go to PARITY if pen=1, else STOP.
REQ-022 Parity bit: sp=0,eps=0 -> odd (XOR of data bits inverted); sp=0,eps=1 -> even (XOR); sp=1,eps=1 -> 0; sp=1,eps=0 -> 1.
REQ-023 Parity covers only the 5+wls transmitted bits; unused upper bits of the byte are ignored.
REQ-024 PARITY held OSR ticks, then STOP.
REQ-025 STOP: tx=1 for OSR ticks (stb=0), 3*OSR/2 ticks (stb=1, wls=00), 2*OSR ticks (stb=1, otherwise).
REQ-026 On the final STOP tick: if fifo_empty=0, pop and load in that same clk and go to START (zero idle gap); else go to IDLE.
REQ-027 Tick counter is 5 bits wide, resets to 0 on each state entry, advances only on baud_pulse.
REQ-028 Clocks without baud_pulse hold all state, counters and tx.
REQ-029 fifo_pop is never asserted while fifo_empty=1, and at most once per frame.
REQ-030 set_break=1 forces tx=0 combinationally over the state-machine value; framing continues unaffected; on release tx resumes the state-machine value.
REQ-031 tx is a registered output (except break override); no glitches at state transitions.

Reset
REQ-032 rst=0 asynchronously forces: state IDLE, tx=1, fifo_pop=0, tx_busy=0, temt=fifo_empty, counters and shift register 0.
REQ-033 Reset asserted mid-frame aborts the frame; no pop is issued until after the first clk following rst deassertion.

Verification
REQ-034 OSR=16, wls=11, pen=0, stb=0, FIFO holds 0xA5: -> one fifo_pop; tx sequence 0,1,0,1,0,0,1,0,1,1 each 16 ticks; then temt=1.
REQ-035 wls=00, pen=1, eps=0, sp=0, byte 0xE3 (data bits 00011, two ones): -> parity bit 1; stb=1 gives a 24-tick stop.
REQ-036 Two bytes 0x55, 0x0F queued: -> second fifo_pop on the final stop tick of frame 1; START of frame 2 immediately follows with no idle ticks.
REQ-037 sp=1: eps=1 -> parity 0, eps=0 -> parity 1, for bytes 0x00 and 0xFF at wls=11.
REQ-038 set_break asserted during DATA of 0xFF: -> tx=0 while asserted; frame ends at the same tick count as without break.
REQ-039 rst pulsed low during DATA bit 3: -> tx=1 and tx_busy=0 immediately; the next frame restarts cleanly from the next FIFO byte.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit framer: pops bytes from a TX FIFO and serialises start/data/parity/stop bits.
// Latency: FIFO pop to start bit one clk; every bit lasts OSR baud_pulse ticks.
// Backpressure: pops only when the FIFO is non-empty; frames are sent back to back with no idle gap.
module uart_tx_engine #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       set_break,
  output logic       tx,
  output logic       tx_busy,
  output logic       temt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Terminal counts of the 5-bit tick counter (count runs 0 .. limit-1).
  localparam logic [4:0] L_BIT    = 5'(OSR - 1);
  localparam logic [4:0] L_STOP15 = 5'((3 * OSR) / 2 - 1);
  localparam logic [4:0] L_STOP2  = 5'(2 * OSR - 1);

  logic [2:0] r_state;
  logic [4:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [1:0] r_wls;
  logic       r_stb;
  logic       r_pen;
  logic       r_par;
  logic       r_tx;
  logic       r_run;

  logic [4:0] w_lim;
  logic       w_last_tick;
  logic       w_last_bit;
  logic       w_load;
  logic [7:0] w_mask;
  logic       w_xor;
  logic       w_par;

  // Length of the current bit period; only the stop period varies, using the latched format.
  always_comb begin
    w_lim = L_BIT;
    if (r_state == S_STOP && r_stb) begin
      w_lim = (r_wls == 2'b00) ? L_STOP15 : L_STOP2;
    end
  end

  // Parity of the incoming byte restricted to the bits that will actually be sent.
  always_comb begin
    w_mask = 8'hFF;
    case (wls)
      2'b00:   w_mask = 8'h1F;
      2'b01:   w_mask = 8'h3F;
      2'b10:   w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
    w_xor = ^(fifo_dout & w_mask);
    w_par = sp ? ~eps : (eps ? w_xor : ~w_xor);
  end

  assign w_last_tick = baud_pulse && (r_state != S_IDLE) && (r_cnt == w_lim);
  // Last data bit index is 4 + wls, which is simply {1, wls}.
  assign w_last_bit  = (r_bit == {1'b1, r_wls});
  // r_run holds off any pop until one clk has passed after reset release.
  assign w_load      = r_run && !fifo_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last_tick));

  assign fifo_pop = w_load;
  assign tx_busy  = (r_state != S_IDLE);
  assign temt     = (r_state == S_IDLE) && fifo_empty;
  assign tx       = set_break ? 1'b0 : r_tx;

  // Frame state machine; tx is registered alongside the state so it changes only on transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_wls   <= 2'd0;
      r_stb   <= 1'b0;
      r_pen   <= 1'b0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_load) begin
        r_state <= S_START;
        r_cnt   <= 5'd0;
        r_bit   <= 3'd0;
        r_shift <= fifo_dout;
        r_wls   <= wls;
        r_stb   <= stb;
        r_pen   <= pen;
        r_par   <= w_par;
        r_tx    <= 1'b0;
      end else if (baud_pulse && (r_state != S_IDLE)) begin
        if (r_cnt != w_lim) begin
          r_cnt <= r_cnt + 5'd1;
        end else begin
          r_cnt <= 5'd0;
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end
            S_DATA: begin
              if (w_last_bit) begin
                if (r_pen) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
              end
            end
            S_PARITY: begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
            default: begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: behavioural FIFO, per-tick expected serial stream scoreboard.
// Expected ticks are generated from the frame format when a byte is queued.
// Bit timing uses a baud_pulse every third clk so idle clks between ticks are exercised.
module tb_uart_tx_engine;

  localparam int OSR = 16;

  typedef struct {
    logic b;
    int   id;
  } tick_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_pulse = 1'b0;
  logic [7:0] fifo_dout = 8'd0;
  logic       fifo_empty = 1'b1;
  logic       fifo_pop;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic       set_break = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       temt;

  tick_t      exp_q[$];
  logic [7:0] fifo_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fid = 0;
  int         pushed = 0;
  int         pop_cnt = 0;
  int         busy_pops = 0;
  int         ticks_seen = 0;
  int         baud_div = 0;
  logic       pop_pending = 1'b0;

  uart_tx_engine #(.OSR(OSR)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .wls(wls), .stb(stb),
    .pen(pen), .eps(eps), .sp(sp), .set_break(set_break), .tx(tx),
    .tx_busy(tx_busy), .temt(temt)
  );

  always #5 clk = ~clk;

  // FIFO model and baud generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'd0;
    baud_div   = (baud_div + 1) % 3;
    baud_pulse = (baud_div == 0);
  end

  // Pop monitor and per-tick serial line scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    tick_t e;
    logic  ev;
    if (fifo_pop) begin
      pop_pending = 1'b1;
      pop_cnt++;
      if (tx_busy) busy_pops++;
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL pop_when_empty: fifo_pop=1 with fifo_empty=1 at %0t", $time);
      end
    end
    if (rst && baud_pulse && tx_busy) begin
      ticks_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: tx=%b while no frame expected at %0t", tx, $time);
      end else begin
        e  = exp_q.pop_front();
        ev = set_break ? 1'b0 : e.b;
        if (tx !== ev) begin
          errors++;
          $display("FAIL tx_tick frame %0d: got %b expected %b at %0t", e.id, tx, ev, $time);
        end
      end
    end
  end

  task automatic add_ticks(input logic v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{b: v, id: fid});
  endtask

  // Queue a byte and its expected serial waveform under the current frame format.
  task automatic push_byte(input logic [7:0] d);
    int         n;
    int         st;
    logic [7:0] m;
    logic       x;
    logic       par;
    n   = 5 + int'(wls);
    m   = 8'hFF >> (8 - n);
    x   = ^(d & m);
    par = sp ? ~eps : (eps ? x : ~x);
    fid++;
    add_ticks(1'b0, OSR);
    for (int i = 0; i < n; i++) add_ticks(d[i], OSR);
    if (pen) add_ticks(par, OSR);
    st = stb ? ((wls == 2'b00) ? (3 * OSR) / 2 : 2 * OSR) : OSR;
    add_ticks(1'b1, st);
    fifo_q.push_back(d);
    pushed++;
  endtask

  task automatic set_fmt(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int cyc;
    target = ticks_seen + n;
    cyc = 0;
    while (ticks_seen < target && cyc < n * 3 + 50) begin
      @(negedge clk);
      cyc++;
    end
    if (ticks_seen < target) begin
      checks++; errors++;
      $display("FAIL wait_ticks_timeout: saw %0d ticks, needed %0d", ticks_seen, target);
    end
  endtask

  // Wait for all queued frames to finish, then check the idle outputs and pop count.
  task automatic wait_done(input string name, input int maxc);
    int  cyc;
    logic done;
    done = 1'b0;
    for (cyc = 0; cyc < maxc && !done; cyc++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && fifo_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d ticks left, busy=%b", name, exp_q.size(), tx_busy);
    end
    checks++;
    if (temt !== 1'b1) begin
      errors++; $display("FAIL %s_temt: got %b expected 1", name, temt);
    end
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL %s_idle_tx: got %b expected 1", name, tx);
    end
    checks++;
    if (pop_cnt !== pushed) begin
      errors++; $display("FAIL %s_pops: got %0d expected %0d", name, pop_cnt, pushed);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", fifo_pop); end
    if (temt !== 1'b1) begin errors++; $display("FAIL reset_temt_empty: got %b expected 1", temt); end
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hC3);
    repeat (3) @(negedge clk);
    checks += 3;
    if (temt !== 1'b0) begin errors++; $display("FAIL reset_temt_full: got %b expected 0", temt); end
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop_full: got %b expected 0", fifo_pop); end
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_full: got %b expected 1", tx); end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL release_pop: got %b expected 0", fifo_pop); end
    wait_done("reset_frame", 2000);
  endtask

  task automatic test_basic;
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hA5);
    wait_done("basic_a5", 2000);
  endtask

  task automatic test_parity_stop;
    set_fmt(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    push_byte(8'hE3);
    wait_done("parity_e3", 2000);
    set_fmt(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    push_byte(8'hB7);
    wait_done("even_7bit", 2000);
  endtask

  task automatic test_back_to_back;
    int gaps;
    int cyc;
    int bp0;
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    bp0 = busy_pops;
    gaps = 0;
    push_byte(8'h55);
    push_byte(8'h0F);
    cyc = 0;
    while (!tx_busy && cyc < 50) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(negedge clk);
      if (!tx_busy && exp_q.size() != 0) gaps++;
      cyc++;
    end
    checks += 2;
    if (gaps !== 0) begin errors++; $display("FAIL b2b_gap: got %0d idle clks expected 0", gaps); end
    if (busy_pops - bp0 !== 1) begin
      errors++; $display("FAIL b2b_stop_pop: got %0d in-frame pops expected 1", busy_pops - bp0);
    end
    wait_done("back_to_back", 200);
  endtask

  task automatic test_stick;
    logic [7:0] bytes [2];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      for (int e = 0; e < 2; e++) begin
        set_fmt(2'b11, 1'b0, 1'b1, e[0], 1'b1);
        push_byte(bytes[i]);
        wait_done("stick", 2000);
      end
    end
  endtask

  task automatic test_latch;
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'h5A);
    wait_ticks(20);
    set_fmt(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_done("format_latch", 2000);
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_break;
    int t0;
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'hFF);
    t0 = ticks_seen;
    wait_ticks(OSR + 2 * OSR);
    set_break = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL break_force: got %b expected 0", tx); end
    wait_ticks(40);
    set_break = 1'b0;
    wait_done("break", 2000);
    checks++;
    if (ticks_seen - t0 !== 10 * OSR) begin
      errors++; $display("FAIL break_length: got %0d ticks expected %0d", ticks_seen - t0, 10 * OSR);
    end
  endtask

  task automatic test_reset_midframe;
    int    f1;
    tick_t keep[$];
    set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_byte(8'h3C);
    f1 = fid;
    push_byte(8'h96);
    wait_ticks(OSR + 3 * OSR + 8);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL midrst_pop: got %b expected 0", fifo_pop); end
    foreach (exp_q[i]) if (exp_q[i].id != f1) keep.push_back(exp_q[i]);
    exp_q = keep;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_pop !== 1'b0) begin errors++; $display("FAIL midrst_release_pop: got %b expected 0", fifo_pop); end
    wait_done("reset_midframe", 2000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_stop();
    test_back_to_back();
    test_stick();
    test_latch();
    test_break();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
